// File: rtl/nn_seq_pkg.sv
// -----------------------------------------------------------------------------
// nn_seq_pkg
// Shared definitions for the neural op program sequencer:
//   - default field / address / loop widths and watchdog limit
//   - opcode enumeration (NOP..LOOP) and sequencer state enumeration
//   - instruction-word width derivation and a generic field-slice helper
// -----------------------------------------------------------------------------
package nn_seq_pkg;

  localparam int OP_SIZE_DEF        = 4;
  localparam int PARAM_A_SIZE_DEF   = 4;
  localparam int PARAM_B_SIZE_DEF   = 4;
  localparam int ADDR_W_DEF         = 8;
  localparam int LOOP_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ACT     = 4'd1,
    OP_DENSE   = 4'd2,
    OP_COST    = 4'd3,
    OP_HALT    = 4'd4,
    OP_SETLOOP = 4'd5,
    OP_LOOP    = 4'd6
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Instruction word = opcode | param A | param B, opcode in the MSBs.
  function automatic int code_w(input int op_w, input int a_w, input int b_w);
    return op_w + a_w + b_w;
  endfunction

  // Extract `width` bits starting at bit `lsb`; callers size-cast the result.
  function automatic logic [63:0] field_slice(input logic [63:0] code,
                                              input int lsb,
                                              input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (code >> lsb) & mask;
  endfunction

endpackage

// File: rtl/nn_op_fields.sv
// -----------------------------------------------------------------------------
// nn_op_fields
// Registered splitter for an instruction word. When load_i is high the word is
// split into opcode / act_type / dense_type / cost_type registers; otherwise
// the registers hold. All fields reset to 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture code_i this cycle
//   code_i       instruction word (opcode in the MSBs)
//   op_o         opcode field
//   act_o        param A field (just below the opcode)
//   dense_o      param B field (LSBs)
//   cost_o       param A and param B together (LSBs)
// -----------------------------------------------------------------------------
module nn_op_fields
  import nn_seq_pkg::*;
#(
  parameter int OP_SIZE      = OP_SIZE_DEF,
  parameter int PARAM_A_SIZE = PARAM_A_SIZE_DEF,
  parameter int PARAM_B_SIZE = PARAM_B_SIZE_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      load_i,
  input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] code_i,
  output logic [OP_SIZE-1:0]                        op_o,
  output logic [PARAM_A_SIZE-1:0]                   act_o,
  output logic [PARAM_B_SIZE-1:0]                   dense_o,
  output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]      cost_o
);

  localparam int CODE_W = code_w(OP_SIZE, PARAM_A_SIZE, PARAM_B_SIZE);
  localparam int COST_W = PARAM_A_SIZE + PARAM_B_SIZE;

  logic [OP_SIZE-1:0]      op_q,    op_d;
  logic [PARAM_A_SIZE-1:0] act_q,   act_d;
  logic [PARAM_B_SIZE-1:0] dense_q, dense_d;
  logic [COST_W-1:0]       cost_q,  cost_d;

  // Next-state: slice the incoming word on load, otherwise hold.
  always_comb begin
    op_d    = op_q;
    act_d   = act_q;
    dense_d = dense_q;
    cost_d  = cost_q;
    if (load_i) begin
      op_d    = OP_SIZE'(field_slice(64'(code_i), CODE_W - OP_SIZE, OP_SIZE));
      act_d   = PARAM_A_SIZE'(field_slice(64'(code_i), PARAM_B_SIZE, PARAM_A_SIZE));
      dense_d = PARAM_B_SIZE'(field_slice(64'(code_i), 0, PARAM_B_SIZE));
      cost_d  = COST_W'(field_slice(64'(code_i), 0, COST_W));
    end else begin
      op_d    = op_q;
      act_d   = act_q;
      dense_d = dense_q;
      cost_d  = cost_q;
    end
  end

  // Field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= {OP_SIZE{1'b0}};
      act_q   <= {PARAM_A_SIZE{1'b0}};
      dense_q <= {PARAM_B_SIZE{1'b0}};
      cost_q  <= {COST_W{1'b0}};
    end else begin
      op_q    <= op_d;
      act_q   <= act_d;
      dense_q <= dense_d;
      cost_q  <= cost_d;
    end
  end

  assign op_o    = op_q;
  assign act_o   = act_q;
  assign dense_o = dense_q;
  assign cost_o  = cost_q;

endmodule

// File: rtl/nn_op_sequencer.sv
// -----------------------------------------------------------------------------
// nn_op_sequencer
// Program sequencer for the neural op datapath. Fetches instruction words,
// executes control ops (NOP, HALT, SETLOOP, LOOP) internally and offers compute
// ops (ACT, DENSE, COST) to the execution units over valid/ready, then waits
// for exec_done before moving on.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: run program from address 0 (ignored while busy)
//   busy / done       running / one-cycle pulse on HALT
//   error             sticky: illegal opcode, pc overflow or watchdog timeout
//   imem_rd/addr/data program memory read, data valid one cycle after imem_rd
//   exec_valid/ready  compute op handshake
//   exec_op/act_type/dense_type/cost_type  fields of the offered op
//   exec_done         pulse: issued op complete
// Build option: define NN_SEQ_WATCHDOG_EN to abort ops that stall for
// TIMEOUT_CYCLES cycles in ISSUE or WAIT_DONE.
// -----------------------------------------------------------------------------
module nn_op_sequencer
  import nn_seq_pkg::*;
#(
  parameter int OP_SIZE        = OP_SIZE_DEF,
  parameter int PARAM_A_SIZE   = PARAM_A_SIZE_DEF,
  parameter int PARAM_B_SIZE   = PARAM_B_SIZE_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LOOP_W         = LOOP_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         error,
  output logic                                         imem_rd,
  output logic [ADDR_W-1:0]                            imem_addr,
  input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] imem_data,
  output logic                                         exec_valid,
  input  logic                                         exec_ready,
  output logic [OP_SIZE-1:0]                           exec_op,
  output logic [PARAM_A_SIZE-1:0]                      exec_act_type,
  output logic [PARAM_B_SIZE-1:0]                      exec_dense_type,
  output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]         exec_cost_type,
  input  logic                                         exec_done
);

  localparam int CODE_W = code_w(OP_SIZE, PARAM_A_SIZE, PARAM_B_SIZE);
  localparam int COST_W = PARAM_A_SIZE + PARAM_B_SIZE;

  localparam logic [OP_SIZE-1:0] L_NOP     = OP_SIZE'(OP_NOP);
  localparam logic [OP_SIZE-1:0] L_ACT     = OP_SIZE'(OP_ACT);
  localparam logic [OP_SIZE-1:0] L_DENSE   = OP_SIZE'(OP_DENSE);
  localparam logic [OP_SIZE-1:0] L_COST    = OP_SIZE'(OP_COST);
  localparam logic [OP_SIZE-1:0] L_HALT    = OP_SIZE'(OP_HALT);
  localparam logic [OP_SIZE-1:0] L_SETLOOP = OP_SIZE'(OP_SETLOOP);
  localparam logic [OP_SIZE-1:0] L_LOOP    = OP_SIZE'(OP_LOOP);

  localparam logic [ADDR_W-1:0] PC_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_MAX    = {ADDR_W{1'b1}};
  localparam logic [LOOP_W-1:0] LOOP_ZERO = {LOOP_W{1'b0}};
  localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1'b1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
  logic                error_q, error_d;
  logic                busy_q, done_q, imem_rd_q, exec_valid_q;
  logic [ADDR_W-1:0]   imem_addr_q;

  logic [OP_SIZE-1:0]  op_raw_s;
  logic [COST_W-1:0]   cost_raw_s;
  state_e              adv_state_s;
  logic [ADDR_W-1:0]   adv_pc_s;
  logic                adv_err_s;
  logic                fields_load_s;
  logic                wd_expired_s;

  // Raw decode of the word on imem_data (valid in DECODE); control ops use
  // these directly so the exec_* registers keep the last issued op.
  always_comb begin
    op_raw_s   = OP_SIZE'(field_slice(64'(imem_data), CODE_W - OP_SIZE, OP_SIZE));
    cost_raw_s = COST_W'(field_slice(64'(imem_data), 0, COST_W));
  end

  // Sequential advance: pc++ unless that would wrap, which is an error.
  always_comb begin
    if (pc_q == PC_MAX) begin
      adv_state_s = ST_HALT;
      adv_pc_s    = pc_q;
      adv_err_s   = 1'b1;
    end else begin
      adv_state_s = ST_FETCH;
      adv_pc_s    = pc_q + PC_ONE;
      adv_err_s   = 1'b0;
    end
  end

`ifdef NN_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_stall_s;

  // Watchdog: counts consecutive stalled cycles in ISSUE / WAIT_DONE.
  always_comb begin
    wd_stall_s   = ((state_q == ST_ISSUE) && !exec_ready) ||
                   ((state_q == ST_WAIT_DONE) && !exec_done);
    wd_expired_s = wd_stall_s && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    if (wd_stall_s && !wd_expired_s) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1'b1);
    end else begin
      wd_cnt_d = {WD_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= {WD_W{1'b0}};
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  // Without the watchdog the sequencer waits indefinitely.
  always_comb begin
    wd_expired_s = 1'b0;
  end
`endif

  // Next-state logic for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    loop_cnt_d    = loop_cnt_q;
    error_d       = error_q;
    fields_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = PC_ZERO;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (op_raw_s)
          L_NOP: begin
            state_d = adv_state_s;
            pc_d    = adv_pc_s;
            error_d = error_q | adv_err_s;
          end
          L_SETLOOP: begin
            loop_cnt_d = LOOP_W'(cost_raw_s);
            state_d    = adv_state_s;
            pc_d       = adv_pc_s;
            error_d    = error_q | adv_err_s;
          end
          L_LOOP: begin
            if (loop_cnt_q != LOOP_ZERO) begin
              loop_cnt_d = loop_cnt_q - LOOP_ONE;
              pc_d       = ADDR_W'(cost_raw_s);
              state_d    = ST_FETCH;
            end else begin
              state_d = adv_state_s;
              pc_d    = adv_pc_s;
              error_d = error_q | adv_err_s;
            end
          end
          L_HALT: begin
            state_d = ST_HALT;
          end
          L_ACT, L_DENSE, L_COST: begin
            fields_load_s = 1'b1;
            state_d       = ST_ISSUE;
          end
          default: begin
            error_d = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_ISSUE: begin
        if (exec_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (wd_expired_s) begin
          error_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (exec_done) begin
          state_d = adv_state_s;
          pc_d    = adv_pc_s;
          error_d = error_q | adv_err_s;
        end else if (wd_expired_s) begin
          error_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_HALT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, architectural registers and registered outputs (decoded from the
  // next state so each output lines up with the state it belongs to).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_ZERO;
      loop_cnt_q   <= LOOP_ZERO;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      imem_rd_q    <= 1'b0;
      imem_addr_q  <= PC_ZERO;
      exec_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      loop_cnt_q   <= loop_cnt_d;
      error_q      <= error_d;
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      done_q       <= (state_d == ST_HALT);
      imem_rd_q    <= (state_d == ST_FETCH);
      imem_addr_q  <= (state_d == ST_FETCH) ? pc_d : imem_addr_q;
      exec_valid_q <= (state_d == ST_ISSUE);
    end
  end

  nn_op_fields #(
    .OP_SIZE      (OP_SIZE),
    .PARAM_A_SIZE (PARAM_A_SIZE),
    .PARAM_B_SIZE (PARAM_B_SIZE)
  ) u_fields (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (fields_load_s),
    .code_i  (imem_data),
    .op_o    (exec_op),
    .act_o   (exec_act_type),
    .dense_o (exec_dense_type),
    .cost_o  (exec_cost_type)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign imem_rd    = imem_rd_q;
  assign imem_addr  = imem_addr_q;
  assign exec_valid = exec_valid_q;

endmodule

// File: tb/tb_nn_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_op_sequencer
// Directed programs with hand-computed expected exec transactions and HALT
// outcomes pushed into queues; independent monitors pop and compare whenever
// the DUT accepts an op or pulses done.
// -----------------------------------------------------------------------------
module tb_nn_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, error, imem_rd;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic        exec_valid, exec_ready, exec_done;
  logic [3:0]  exec_op, exec_act_type, exec_dense_type;
  logic [7:0]  exec_cost_type;

  nn_op_sequencer #(
    .OP_SIZE(4), .PARAM_A_SIZE(4), .PARAM_B_SIZE(4),
    .ADDR_W(8), .LOOP_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .error(error),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .exec_valid(exec_valid), .exec_ready(exec_ready),
    .exec_op(exec_op), .exec_act_type(exec_act_type),
    .exec_dense_type(exec_dense_type), .exec_cost_type(exec_cost_type),
    .exec_done(exec_done)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] act;
    logic [3:0] dense;
    logic [7:0] cost;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_err_q[$];
  logic [11:0] mem [256];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  int          done_delay = 2;
  logic        respond_en = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  // Scoreboard monitor: accepted exec ops.
  initial begin
    exp_t act_v, exp_v;
    forever begin
      @(negedge clk);
      if (exec_valid && exec_ready) begin
        acc_cnt++;
        act_v = {exec_op, exec_act_type, exec_dense_type, exec_cost_type};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL exec_unexpected got=%h", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL exec_fields got=%h want=%h", act_v, exp_v);
          end
        end
      end
    end
  end

  // Scoreboard monitor: HALT outcomes (done pulse with error flag, busy low).
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      if (done) begin
        total++;
        if (exp_err_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected error=%b", error);
        end else begin
          e = exp_err_q.pop_front();
          if (error !== e || busy !== 1'b0) begin
            bad++;
            $display("FAIL halt_state error=%b busy=%b want error=%b busy=0", error, busy, e);
          end
        end
      end
    end
  end

  // Execution unit model: pulse exec_done done_delay cycles after acceptance.
  initial begin
    exec_done = 1'b0;
    forever begin
      @(negedge clk);
      if (exec_valid && exec_ready && respond_en) begin
        @(posedge clk);
        repeat (done_delay - 1) @(posedge clk);
        #1 exec_done = 1'b1;
        @(posedge clk);
        #1 exec_done = 1'b0;
      end
    end
  end

  // Absolute time limit.
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic load_prog(input logic [11:0] w0, input logic [11:0] w1,
                           input logic [11:0] w2, input logic [11:0] w3);
    for (int i = 0; i < 256; i++) mem[i] = 12'h400;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, done, error, imem_rd, exec_valid, imem_addr,
                 exec_op, exec_act_type, exec_dense_type, exec_cost_type}, 32'd0);
  endtask

  initial begin
    int a0, n;
    rst_n = 1'b0; start = 1'b0; exec_ready = 1'b0;
    load_prog(12'h400, 12'h400, 12'h400, 12'h400);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1 rst_n = 1'b1;

    // {ACT a=3, HALT}
    load_prog(12'h130, 12'h400, 12'h400, 12'h400);
    exec_ready = 1'b1; done_delay = 2; a0 = acc_cnt;
    exp_q.push_back('{op: 4'h1, act: 4'h3, dense: 4'h0, cost: 8'h30});
    exp_err_q.push_back(1'b0);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("act_done", 50);
    check("act_accepts", acc_cnt - a0, 32'd1);
    check("act_busy_low", {31'd0, busy}, 32'd0);

    // DENSE 0x205 with exec_ready held low
    load_prog(12'h205, 12'h400, 12'h400, 12'h400);
    exec_ready = 1'b0; a0 = acc_cnt;
    exp_q.push_back('{op: 4'h2, act: 4'h0, dense: 4'h5, cost: 8'h05});
    exp_err_q.push_back(1'b0);
    pulse_start();
    n = 0;
    while (exec_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("dense_hold", {27'd0, exec_valid, exec_dense_type}, {27'd0, 1'b1, 4'h5});
      @(negedge clk);
    end
    @(posedge clk); #1 exec_ready = 1'b1;
    wait_done("dense_done", 50);
    check("dense_accepts", acc_cnt - a0, 32'd1);

    // {SETLOOP 2, COST 0x3A7, LOOP->1, HALT}
    load_prog(12'h502, 12'h3A7, 12'h601, 12'h400);
    done_delay = 1; a0 = acc_cnt;
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{op: 4'h3, act: 4'hA, dense: 4'h7, cost: 8'hA7});
    exp_err_q.push_back(1'b0);
    pulse_start();
    wait_done("loop_done", 150);
    check("loop_accepts", acc_cnt - a0, 32'd3);

    // Illegal opcode at address 0, then a clean run clears error
    load_prog(12'hF00, 12'h400, 12'h400, 12'h400);
    a0 = acc_cnt;
    exp_err_q.push_back(1'b1);
    pulse_start();
    wait_done("illegal_done", 50);
    check("illegal_no_issue", acc_cnt - a0, 32'd0);
    check("illegal_error_sticky", {31'd0, error}, 32'd1);
    load_prog(12'h400, 12'h400, 12'h400, 12'h400);
    exp_err_q.push_back(1'b0);
    pulse_start();
    @(negedge clk);
    check("error_cleared_on_start", {31'd0, error}, 32'd0);
    wait_done("clean_done", 50);

    // Reset asserted during WAIT_DONE
    load_prog(12'h130, 12'h400, 12'h400, 12'h400);
    respond_en = 1'b0; a0 = acc_cnt;
    exp_q.push_back('{op: 4'h1, act: 4'h3, dense: 4'h0, cost: 8'h30});
    pulse_start();
    n = 0;
    while (acc_cnt == a0 && n < 30) begin @(negedge clk); n++; end
    check("rst_test_accepted", acc_cnt - a0, 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    respond_en = 1'b1;
    exp_q.push_back('{op: 4'h1, act: 4'h3, dense: 4'h0, cost: 8'h30});
    exp_err_q.push_back(1'b0);
    pulse_start();
    n = 0;
    while (imem_rd !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("refetch_addr0", {23'd0, imem_rd, imem_addr}, {23'd0, 1'b1, 8'h00});
    wait_done("rst_rerun_done", 50);

    // exec_done never arrives
    load_prog(12'h130, 12'h400, 12'h400, 12'h400);
    respond_en = 1'b0;
    exp_q.push_back('{op: 4'h1, act: 4'h3, dense: 4'h0, cost: 8'h30});
`ifdef NN_SEQ_WATCHDOG_EN
    exp_err_q.push_back(1'b1);
    pulse_start();
    wait_done("watchdog_done", 60);
    check("watchdog_error", {31'd0, error}, 32'd1);
`else
    pulse_start();
    repeat (40) @(negedge clk);
    check("no_watchdog_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif
    respond_en = 1'b1;
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_err_q_drained", exp_err_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
